frame_sync: RTL and testbench

FRAME_SYNC -- requirements
Module: frame_sync

---
 rtl/frame_sync.sv | 141 ++++++++++++++
 tb/tb_frame_sync.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync.sv
// Frame aligner: hunts for the F6F6F6282828 FAS, confirms it one frame later, then tracks row/col.
// Latency 1 cycle (all outputs registered); no backpressure, the stream advances only on i_valid.
module frame_sync #(
  parameter int LOSS_THRESH = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_in_frame,
  output logic        o_frame_start,
  output logic        o_fas_err
);

  localparam logic [47:0] FAS      = 48'hF6F6F6_282828;
  localparam logic [10:0] LAST_COL = 11'd1040;
  localparam logic [10:0] FAS_COL  = 11'd5;
  localparam logic [2:0]  THRESH   = 3'(LOSS_THRESH);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PRESYNC = 2'd1,
    ST_SYNC    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [39:0] r_window;
  logic [47:0] w_window;
  logic [1:0]  r_row;
  logic [10:0] r_col;
  logic [2:0]  r_miss;
  logic        w_match;
  logic        w_check_byte;
  logic        w_miss_limit;
  logic        w_fas_fail;
  logic        w_frame_start;
  logic [1:0]  w_row_out;
  logic [10:0] w_col_out;

  logic        r_valid;
  logic [7:0]  r_data;
  logic [1:0]  r_row_out;
  logic [10:0] r_col_out;
  logic        r_in_frame;
  logic        r_frame_start;
  logic        r_fas_err;

  // Only the five previous bytes are stored; the live byte completes the six-byte window.
  assign w_window     = {r_window, i_data};
  assign w_match      = i_valid && (w_window == FAS);
  assign w_check_byte = i_valid && (r_state != ST_HUNT) && (r_row == 2'd0) && (r_col == FAS_COL);
  assign w_miss_limit = (r_miss + 3'd1) == THRESH;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_HUNT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT:    if (w_match) w_state_nxt = ST_PRESYNC;
      ST_PRESYNC: if (w_check_byte) w_state_nxt = w_match ? ST_SYNC : ST_HUNT;
      ST_SYNC:    if (w_check_byte && !w_match && w_miss_limit) w_state_nxt = ST_HUNT;
      default:    w_state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    w_fas_fail    = w_check_byte && !w_match;
    w_frame_start = i_valid && (r_state == ST_SYNC) && (r_row == 2'd0) && (r_col == 11'd0);
    w_row_out     = r_row;
    w_col_out     = r_col;
    if (r_state == ST_HUNT) begin
      w_row_out = 2'd0;
      w_col_out = w_match ? FAS_COL : 11'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_window <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_miss   <= '0;
    end else if (i_valid) begin
      r_window <= w_window[39:0];
      if (w_state_nxt == ST_HUNT) begin
        r_row <= 2'd0;
        r_col <= 11'd0;
      end else if (r_state == ST_HUNT) begin
        r_row <= 2'd0;
        r_col <= 11'd6;
      end else if (r_col == LAST_COL) begin
        r_row <= r_row + 2'd1;
        r_col <= 11'd0;
      end else begin
        r_col <= r_col + 11'd1;
      end
      // Miss count is only meaningful in SYNC; every path back to HUNT leaves it cleared.
      if (w_state_nxt == ST_HUNT)                r_miss <= 3'd0;
      else if (w_check_byte && r_state == ST_SYNC) r_miss <= w_match ? 3'd0 : r_miss + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= 1'b0;
      r_data        <= '0;
      r_row_out     <= '0;
      r_col_out     <= '0;
      r_in_frame    <= 1'b0;
      r_frame_start <= 1'b0;
      r_fas_err     <= 1'b0;
    end else begin
      r_valid       <= i_valid;
      r_in_frame    <= (r_state == ST_SYNC);
      r_frame_start <= w_frame_start;
      r_fas_err     <= w_fas_fail;
      if (i_valid) begin
        r_data    <= i_data;
        r_row_out <= w_row_out;
        r_col_out <= w_col_out;
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_data        = r_data;
  assign o_row_cnt     = r_row_out;
  assign o_col_cnt     = r_col_out;
  assign o_in_frame    = r_in_frame;
  assign o_frame_start = r_frame_start;
  assign o_fas_err     = r_fas_err;

endmodule

// File: tb/tb_frame_sync.sv
// Bench for frame_sync: random byte streams scored against a linear-index reference model.
module tb_frame_sync;
  localparam int LOSS  = 5;
  localparam int FRAME = 4164;
  localparam int COLS  = 1041;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_in_frame;
  logic        o_frame_start;
  logic        o_fas_err;

  frame_sync #(.LOSS_THRESH(LOSS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .o_row_cnt(o_row_cnt), .o_col_cnt(o_col_cnt),
    .o_in_frame(o_in_frame), .o_frame_start(o_frame_start), .o_fas_err(o_fas_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pos = 0;
  logic [7:0] fas [6] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};

  // Reference model: state 0=hunt 1=presync 2=sync, position as a linear byte index in the frame.
  logic [7:0]  hist [$];
  int          m_state, m_idx, m_miss;
  logic        e_valid, e_inf, e_fs, e_err;
  logic [7:0]  e_data;
  logic [1:0]  e_row;
  logic [10:0] e_col;
  logic [24:0] expv;
  logic [24:0] obs;
  assign obs = {o_valid, o_data, o_row_cnt, o_col_cnt, o_in_frame, o_frame_start, o_fas_err};

  task automatic model_reset();
    hist = {};
    repeat (6) hist.push_back(8'h00);
    m_state = 0; m_idx = 0; m_miss = 0;
    e_valid = 0; e_inf = 0; e_fs = 0; e_err = 0; e_data = 0; e_row = 0; e_col = 0;
    expv = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    bit match;
    e_valid = v; e_fs = 0; e_err = 0;
    e_inf = (m_state == 2);
    if (v) begin
      hist.push_back(d);
      void'(hist.pop_front());
      match = 1;
      for (int k = 0; k < 6; k++) if (hist[k] != fas[k]) match = 0;
      e_data = d;
      if (m_state == 0) begin
        e_row = 2'd0;
        e_col = match ? 11'd5 : 11'd0;
        if (match) begin m_state = 1; m_idx = 6; end
      end else begin
        e_row = 2'(m_idx / COLS);
        e_col = 11'(m_idx % COLS);
        e_fs  = (m_state == 2) && (m_idx == 0);
        if (m_idx == 5) begin
          if (match) begin
            m_state = 2; m_miss = 0;
          end else begin
            e_err = 1;
            if (m_state == 1) m_state = 0;
            else begin
              m_miss++;
              if (m_miss == LOSS) begin m_state = 0; m_miss = 0; end
            end
          end
        end
        m_idx = (m_state == 0) ? 0 : (m_idx + 1) % FRAME;
      end
    end
    expv = {e_valid, e_data, e_row, e_col, e_inf, e_fs, e_err};
  endtask

  task automatic send_byte(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    model_step(v, d);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hF6) b = 8'h00;
    return b;
  endfunction

  function automatic logic [7:0] frame_byte(input int p, input bit corrupt);
    logic [7:0] b;
    if (p < 6) begin
      b = fas[p];
      if (corrupt && p == 3) b = 8'h00;
    end else begin
      b = rnd_byte();
    end
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 0; i_valid = 1; i_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 25'd0) begin errors++; $display("FAIL reset_hold got=%h want=%h", obs, 25'd0); end
    i_valid = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    send_byte(0, 8'h55);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_idle got=%h want=%h", obs, expv); end
    send_byte(1, 8'h12);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_first_byte got=%h want=%h", obs, expv); end
  endtask

  task automatic test_acquire();
    int lead, fs, first_inf;
    logic [7:0] d;
    lead = $urandom_range(10, 40);
    fs = 0; first_inf = -1; pos = 0;
    for (int k = 0; k < lead + 3 * FRAME; k++) begin
      if (k < lead) d = rnd_byte();
      else begin d = frame_byte(pos, 0); pos = (pos + 1) % FRAME; end
      send_byte(1, d);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL acquire k=%0d got=%h want=%h", k, obs, expv); end
      if (o_frame_start) fs++;
      if (o_in_frame && first_inf < 0) first_inf = k;
      if (k == lead + 5) begin
        checks++;
        if ({o_row_cnt, o_col_cnt, o_in_frame} !== {2'd0, 11'd5, 1'b0}) begin
          errors++;
          $display("FAIL acquire_match_byte row=%0d col=%0d inf=%b want row=0 col=5 inf=0", o_row_cnt, o_col_cnt, o_in_frame);
        end
      end
    end
    checks++;
    if (first_inf != lead + FRAME + 6) begin
      errors++; $display("FAIL acquire_in_frame_rise at=%0d want=%0d", first_inf, lead + FRAME + 6);
    end
    checks++;
    if (fs != 1) begin errors++; $display("FAIL acquire_frame_start count=%0d want=1", fs); end
  endtask

  task automatic test_fas_recovery();
    int errs, drops;
    errs = 0; drops = 0;
    for (int k = 0; k < 5 * FRAME; k++) begin
      send_byte(1, frame_byte(pos, k < 4 * FRAME));
      pos = (pos + 1) % FRAME;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL fas_recovery k=%0d got=%h want=%h", k, obs, expv); end
      if (o_fas_err) errs++;
      if (!o_in_frame) drops++;
    end
    checks++;
    if (errs != 4) begin errors++; $display("FAIL fas_recovery_err_count got=%0d want=4", errs); end
    checks++;
    if (drops != 0) begin errors++; $display("FAIL fas_recovery_in_frame_drops got=%0d want=0", drops); end
  endtask

  task automatic test_valid_toggle();
    int nvalid, fs, wraps, cyc;
    logic [1:0]  prow;
    logic [10:0] pcol;
    logic v;
    logic [7:0] d;
    nvalid = 0; fs = 0; wraps = 0; cyc = 0; prow = 0; pcol = 0;
    while (nvalid < FRAME + 1 && cyc < 4 * FRAME) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin d = frame_byte(pos, 0); pos = (pos + 1) % FRAME; nvalid++; end
      else d = 8'($urandom);
      send_byte(v, d);
      cyc++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL valid_toggle cyc=%0d got=%h want=%h", cyc, obs, expv); end
      if (o_frame_start) fs++;
      if (o_valid) begin
        if (prow == 2'd3 && pcol == 11'd1040 && o_row_cnt == 2'd0 && o_col_cnt == 11'd0) wraps++;
        prow = o_row_cnt; pcol = o_col_cnt;
      end
    end
    checks++;
    if (nvalid != FRAME + 1) begin errors++; $display("FAIL valid_toggle_budget sent=%0d want=%0d", nvalid, FRAME + 1); end
    checks++;
    if (fs != 2) begin errors++; $display("FAIL valid_toggle_frame_start count=%0d want=2", fs); end
    checks++;
    if (wraps != 1) begin errors++; $display("FAIL valid_toggle_wrap count=%0d want=1", wraps); end
  endtask

  task automatic test_async_reset();
    int n;
    while (pos != 2 * COLS + 501) begin
      send_byte(1, frame_byte(pos, 0));
      pos = (pos + 1) % FRAME;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL async_pre pos=%0d got=%h want=%h", pos, obs, expv); end
    end
    checks++;
    if (!o_in_frame) begin errors++; $display("FAIL async_pre_sync inf=%b want=1", o_in_frame); end
    rst_n = 0;
    i_valid = 0;
    #2;
    checks++;
    if (obs !== 25'd0) begin errors++; $display("FAIL async_reset_immediate got=%h want=%h", obs, 25'd0); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    n = (FRAME - pos) + FRAME + 7;
    for (int k = 0; k < n; k++) begin
      send_byte(1, frame_byte(pos, 0));
      pos = (pos + 1) % FRAME;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL async_reacquire k=%0d got=%h want=%h", k, obs, expv); end
    end
    checks++;
    if ({o_in_frame, o_col_cnt} !== {1'b1, 11'd6}) begin
      errors++; $display("FAIL async_reacquired inf=%b col=%0d want inf=1 col=6", o_in_frame, o_col_cnt);
    end
  endtask

  task automatic test_loss();
    int errs, k;
    errs = 0; k = 0;
    while (errs < LOSS && k < 6 * FRAME) begin
      send_byte(1, frame_byte(pos, 1));
      pos = (pos + 1) % FRAME;
      k++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL loss k=%0d got=%h want=%h", k, obs, expv); end
      if (o_fas_err) errs++;
    end
    checks++;
    if (errs != LOSS) begin errors++; $display("FAIL loss_err_count got=%0d want=%0d", errs, LOSS); end
    checks++;
    if (o_in_frame !== 1'b1) begin errors++; $display("FAIL loss_last_fail_in_frame got=%b want=1", o_in_frame); end
    for (int j = 0; j < 20; j++) begin
      send_byte(1, rnd_byte());
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL loss_after j=%0d got=%h want=%h", j, obs, expv); end
    end
    checks++;
    if ({o_in_frame, o_row_cnt, o_col_cnt} !== 14'd0) begin
      errors++; $display("FAIL loss_hunt_outputs inf=%b row=%0d col=%0d want all 0", o_in_frame, o_row_cnt, o_col_cnt);
    end
  endtask

  task automatic test_false_fas();
    int lead, errs, infs, n;
    logic [7:0] d;
    rst_n = 0;
    i_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    lead = $urandom_range(3, 30);
    n = lead + 6 + FRAME + 10;
    errs = 0; infs = 0;
    for (int k = 0; k < n; k++) begin
      if (k >= lead && k < lead + 6) d = fas[k - lead];
      else d = rnd_byte();
      send_byte(1, d);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL false_fas k=%0d got=%h want=%h", k, obs, expv); end
      if (o_fas_err) errs++;
      if (o_in_frame) infs++;
    end
    checks++;
    if (errs != 1) begin errors++; $display("FAIL false_fas_err_count got=%0d want=1", errs); end
    checks++;
    if (infs != 0) begin errors++; $display("FAIL false_fas_in_frame count=%0d want=0", infs); end
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    i_valid = 0;
    i_data = 0;
    model_reset();
    test_reset();
    test_acquire();
    test_fas_recovery();
    test_valid_toggle();
    test_async_reset();
    test_loss();
    test_false_fas();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
